branch_predictor_btb: RTL
=========================

// Module: branch_predictor_btb
// PURPOSE
//  Parametrised branch prediction for the pipelined core: direct-mapped BTB plus 2-bit saturating
//  counter PHT, optional gshare indexing via a global history register. Lookup in IF, same cycle.
//  Update and mispredict detection are driven from the resolve stage (EX/MEM).
//  Replaces the fixed predict-not-taken/flush scheme with a predicted next-PC and a redirect request.
// PARAMETERS
//  XLEN       32  data/address width
//  ENTRIES    16  BTB and PHT entries, power of 2; IDX_W = log2(ENTRIES)
//  TAG_W      8   tag bits, taken from pc[IDX_W+2 +: TAG_W]
//  GHR_W      0   global history bits; 0 = bimodal, >0 = gshare (GHR_W <= IDX_W)
//  PREDICT_EN 1   0 = static not-taken (tables frozen at reset values)
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     asynchronous, active-low reset
//  if_valid        in   1     IF lookup valid (counted only)
//  if_pc           in   XLEN  fetch PC
//  pred_hit        out  1     BTB valid and tag match for if_pc
//  pred_taken      out  1     predicted taken
//  pred_target     out  XLEN  predicted next PC
//  upd_valid       in   1     resolve-stage instruction valid
//  upd_pc          in   XLEN  PC of resolving instruction
//  upd_is_branch   in   1     conditional branch
//  upd_is_jump     in   1     unconditional jump (jal)
//  upd_taken       in   1     actual outcome (ignored when neither flag set)
//  upd_target      in   XLEN  actual taken target
//  upd_pred_taken  in   1     prediction carried down the pipeline
//  upd_pred_target in   XLEN  predicted target carried down the pipeline
//  mispredict      out  1     redirect and flush younger stages
//  redirect_pc     out  XLEN  correct next PC
//  stat_lookups    out  32    saturating count of if_valid cycles
//  stat_mispred    out  32    saturating count of mispredict cycles
// BEHAVIOUR
//  - Reset (rst=0, async): all BTB valid=0, PHT counters=2'b01 (weakly NT), GHR=0, stats=0.
//    Outputs then: pred_hit=0, pred_taken=0, pred_target=if_pc+4, mispredict=0 unless upd_* asserted.
//  - Indices: bidx=pc[IDX_W+1:2]; pidx=bidx ^ {0,ghr} (GHR_W>0), else bidx.
//  - Lookup is combinational, 0 latency: pred_hit=valid[bidx] && tag[bidx]==if_pc tag bits;
//    pred_taken=PREDICT_EN && pred_hit && (jump[bidx] || ctr[pidx][1]);
//    pred_target=pred_taken ? {target[bidx],2'b00} : if_pc+4. Targets stored as [XLEN-1:2].
//  - Mispredict (comb): act_taken=upd_is_jump | (upd_is_branch & upd_taken);
//    mispredict=upd_valid && (act_taken!=upd_pred_taken || (act_taken && upd_target!=upd_pred_target));
//    redirect_pc=act_taken ? upd_target : upd_pc+4. Adds are mod 2^XLEN (wrap, no carry out).
//  - Update on rising edge when upd_valid && PREDICT_EN:
//    act_taken: write BTB[bidx] valid=1, tag, target, jump=upd_is_jump (allocate/overwrite).
//    branch: ctr[pidx] +1 if taken, -1 if not, saturating at 2'b11/2'b00; GHR={GHR[GHR_W-2:0],upd_taken}.
//    not-taken branch with no BTB hit: no allocation. jumps do not touch PHT/GHR.
//    neither flag but upd_pred_taken=1 (alias): mispredict, redirect upd_pc+4, BTB[bidx].valid<=0.
//  - Same-cycle lookup and update to same index: lookup sees pre-update state; new state next cycle.
//  - pidx of update uses GHR before its own shift; lookup always uses committed GHR.
//  - Stats: +1 on if_valid / mispredict each rising edge; hold at 32'hFFFF_FFFF.
//  - Reset asserted mid-update: update discarded, all state cleared immediately.
// TESTING
//  1 Reset, lookup if_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44.
//  2 Update branch pc=0x40 taken target=0x20, upd_pred_taken=0 -> mispredict=1, redirect_pc=0x20;
//    next cycle lookup 0x40 -> pred_hit=1, ctr=2'b10, pred_taken=1, pred_target=0x20.
//  3 Three more taken updates at 0x40 (ctr 11), one NT -> ctr 10 still taken; second NT -> 01,
//    pred_taken=0, pred_target=0x44; lookup 0x80 (same bidx, other tag) -> pred_hit=0.
//  4 Jump pc=0x100 target=0x200 -> lookup 0x100 taken to 0x200 regardless of ctr; alias update
//    pc=0x100 no flags, upd_pred_taken=1 -> mispredict, redirect 0x104, next lookup pred_hit=0.
//  5 GHR_W=2: alternating T/NT branch at 0x40 predicted correctly after warm-up (<=8 updates),
//    stat_mispred stops increasing; PREDICT_EN=0 -> pred_taken always 0.
//  6 rst low mid-cycle during upd_valid -> stats, pred_hit, GHR zero before next edge; entry not written.

Source files
------------

// File: rtl/branch_predictor_btb.sv
// Branch predictor: direct-mapped BTB plus 2-bit saturating counter PHT with
// optional gshare indexing. Lookup is combinational in IF; training and
// mispredict detection come from the resolve stage.
module branch_predictor_btb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ENTRIES    = 16,
  parameter int unsigned TAG_W      = 8,
  parameter int unsigned GHR_W      = 0,
  parameter int unsigned PREDICT_EN = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            if_valid_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_is_branch_i,
  input  logic            upd_is_jump_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [XLEN-1:0] upd_pred_target_i,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [31:0]     stat_lookups_o,
  output logic [31:0]     stat_mispred_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned GHR_L = (GHR_W > 0) ? GHR_W : 1;
  localparam int unsigned TGT_W = XLEN - 2;
  localparam int unsigned STAT_W = 32;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] jump_q, jump_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [TGT_W-1:0]   target_q [ENTRIES];
  logic [TGT_W-1:0]   target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [GHR_L-1:0]   ghr_q, ghr_d;
  logic [STAT_W-1:0]  lookups_q, lookups_d;
  logic [STAT_W-1:0]  mispred_q, mispred_d;

  logic [IDX_W-1:0] lk_bidx, lk_pidx, up_bidx, up_pidx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             act_taken;
  logic             lk_hit;

  assign lk_bidx = if_pc_i[IDX_W+1:2];
  assign lk_tag  = if_pc_i[IDX_W+2 +: TAG_W];
  assign up_bidx = upd_pc_i[IDX_W+1:2];
  assign up_tag  = upd_pc_i[IDX_W+2 +: TAG_W];

  // PHT index: gshare folds committed history into the low index bits
  if (GHR_W > 0) begin : g_gshare
    assign lk_pidx = lk_bidx ^ IDX_W'(ghr_q);
    assign up_pidx = up_bidx ^ IDX_W'(ghr_q);
  end else begin : g_bimodal
    assign lk_pidx = lk_bidx;
    assign up_pidx = up_bidx;
  end

  // Bits of the PCs above the tag and below the word offset carry no state
  logic unused_bits;
  assign unused_bits = ^{if_pc_i, upd_pc_i, ghr_q};

  // Same-cycle lookup against committed table state
  always_comb begin
    lk_hit        = valid_q[lk_bidx] && (tag_q[lk_bidx] == lk_tag);
    pred_hit_o    = lk_hit;
    pred_taken_o  = (PREDICT_EN != 0) && lk_hit &&
                    (jump_q[lk_bidx] || ctr_q[lk_pidx][1]);
    pred_target_o = pred_taken_o ? {target_q[lk_bidx], 2'b00}
                                 : if_pc_i + XLEN'(4);
  end

  // Resolve-stage outcome check and redirect address
  always_comb begin
    act_taken     = upd_is_jump_i | (upd_is_branch_i & upd_taken_i);
    mispredict_o  = upd_valid_i &&
                    ((act_taken != upd_pred_taken_i) ||
                     (act_taken && (upd_target_i != upd_pred_target_i)));
    redirect_pc_o = act_taken ? upd_target_i : upd_pc_i + XLEN'(4);
  end

  // Next table, history and statistics state
  always_comb begin
    valid_d   = valid_q;
    jump_d    = jump_q;
    tag_d     = tag_q;
    target_d  = target_q;
    ctr_d     = ctr_q;
    ghr_d     = ghr_q;
    lookups_d = lookups_q;
    mispred_d = mispred_q;

    if (upd_valid_i && (PREDICT_EN != 0)) begin
      if (act_taken) begin
        valid_d[up_bidx]  = 1'b1;
        tag_d[up_bidx]    = up_tag;
        target_d[up_bidx] = upd_target_i[XLEN-1:2];
        jump_d[up_bidx]   = upd_is_jump_i;
      end else if (!upd_is_branch_i && !upd_is_jump_i && upd_pred_taken_i) begin
        // non-branch aliased onto a BTB entry: drop the entry
        valid_d[up_bidx] = 1'b0;
      end

      if (upd_is_branch_i && !upd_is_jump_i) begin
        if (upd_taken_i && (ctr_q[up_pidx] != 2'b11)) begin
          ctr_d[up_pidx] = ctr_q[up_pidx] + 2'd1;
        end else if (!upd_taken_i && (ctr_q[up_pidx] != 2'b00)) begin
          ctr_d[up_pidx] = ctr_q[up_pidx] - 2'd1;
        end
        ghr_d = GHR_L'({ghr_q, upd_taken_i});
      end
    end

    if (if_valid_i && (lookups_q != '1)) begin
      lookups_d = lookups_q + STAT_W'(1);
    end
    if (mispredict_o && (mispred_q != '1)) begin
      mispred_d = mispred_q + STAT_W'(1);
    end
  end

  // State register; reset clears every entry to invalid / weakly not-taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      jump_q    <= '0;
      ghr_q     <= '0;
      lookups_q <= '0;
      mispred_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q   <= valid_d;
      jump_q    <= jump_d;
      tag_q     <= tag_d;
      target_q  <= target_d;
      ctr_q     <= ctr_d;
      ghr_q     <= ghr_d;
      lookups_q <= lookups_d;
      mispred_q <= mispred_d;
    end
  end

  assign stat_lookups_o = lookups_q;
  assign stat_mispred_o = mispred_q;

endmodule
